// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/stall controller
package hazard_pkg;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_VBNZ  = 2'b10;
  localparam logic [1:0] BR_VBENZ = 2'b11;

  // Widest register address the shadow entries can hold; narrower
  // configurations are zero-extended on entry.
  localparam int RD_W_MAX = 8;

  typedef struct packed {
    logic                v;
    logic [RD_W_MAX-1:0] rd;
    logic                load;
  } shadow_entry_t;

  typedef enum logic {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - ID/EX sequencing bus between decoder side and the controller
interface hazard_stall_controller_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              id_valid;
  logic [REG_AW-1:0] id_hdu_a;
  logic [REG_AW-1:0] id_hdu_b;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr_en;
  logic              id_load;
  logic [1:0]        id_br;
  logic              ex_br_valid;
  logic              ex_br_taken;

  logic              stall_if;
  logic              bubble_ex;
  logic              issue;
  logic              flush_id;
  logic              br_pending;
  logic              br_err;
  logic [CNT_W-1:0]  stall_cnt;

  // Pipeline side: presents the decoded instruction and branch resolution
  modport master (
    output id_valid, id_hdu_a, id_hdu_b, id_rd, id_wr_en, id_load, id_br,
           ex_br_valid, ex_br_taken,
    input  stall_if, bubble_ex, issue, flush_id, br_pending, br_err, stall_cnt
  );

  // Controller side
  modport slave (
    input  id_valid, id_hdu_a, id_hdu_b, id_rd, id_wr_en, id_load, id_br,
           ex_br_valid, ex_br_taken,
    output stall_if, bubble_ex, issue, flush_id, br_pending, br_err, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB shadow of in-flight destinations and RAW match; FORWARDING_EN selects load-use-only stalls
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int HAZ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,
  input  logic              id_valid,
  input  logic              id_wr_en,
  input  logic              id_load,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  output logic              data_haz
);

  // Entry 0 = EX, 1 = MEM, 2 = WB
  localparam logic [2:0] DEPTH_MASK = (HAZ_DEPTH >= 3) ? 3'b111 :
                                      (HAZ_DEPTH == 2) ? 3'b011 : 3'b001;

  shadow_entry_t       pipe [3];
  shadow_entry_t       ex_nxt;
  logic [RD_W_MAX-1:0] sa;
  logic [RD_W_MAX-1:0] sb;
  logic [2:0]          hit;
  logic [2:0]          loads;
  logic                load_use;

  // Build the entry that enters EX; a non-issuing cycle sends an empty slot
  always_comb begin
    ex_nxt      = '0;
    ex_nxt.v    = issue & id_wr_en;
    ex_nxt.rd   = RD_W_MAX'(id_rd);
    ex_nxt.load = issue & id_load;
  end

  // Shadow shift register tracking the pipeline stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe[0] <= '0;
      pipe[1] <= '0;
      pipe[2] <= '0;
    end else begin
      pipe[0] <= ex_nxt;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
  end

  // Per-entry source match; address 0 is the decoder's "unused" code, never a hazard
  always_comb begin
    sa    = RD_W_MAX'(src_a);
    sb    = RD_W_MAX'(src_b);
    hit   = '0;
    loads = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i]   = pipe[i].v && (((sa == pipe[i].rd) && (sa != '0)) ||
                               ((sb == pipe[i].rd) && (sb != '0)));
      loads[i] = pipe[i].load;
    end
  end

  // Load-use is only possible against EX, which is always inside the window
  assign load_use = |(hit & loads & 3'b001);

`ifdef FORWARDING_EN
  // Bypass covers everything except a load whose data is not back yet
  assign data_haz = id_valid & load_use;
`else
  // No bypass: any producer still in the compared window blocks issue
  assign data_haz = id_valid & ((|(hit & DEPTH_MASK)) | load_use);
`endif

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - ID issue/stall/flush sequencing with branch-wait FSM and stall counter; option FORWARDING_EN
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int HAZ_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input logic                      clk,
  input logic                      reset_n,
  hazard_stall_controller_if.slave bus
);

  fsm_state_t       state;
  fsm_state_t       state_nxt;
  logic             data_haz;
  logic             stall_c;
  logic             issue_c;
  logic             flush_c;
  logic             br_err_q;
  logic [CNT_W-1:0] stall_cnt_q;

  hazard_scoreboard #(
    .REG_AW    (REG_AW),
    .HAZ_DEPTH (HAZ_DEPTH)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .issue    (issue_c),
    .id_valid (bus.id_valid),
    .id_wr_en (bus.id_wr_en),
    .id_load  (bus.id_load),
    .id_rd    (bus.id_rd),
    .src_a    (bus.id_hdu_a),
    .src_b    (bus.id_hdu_b),
    .data_haz (data_haz)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and issue/stall/flush decisions
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    issue_c   = 1'b0;
    flush_c   = 1'b0;
    case (state)
      IDLE: begin
        stall_c = data_haz;
        issue_c = bus.id_valid & ~data_haz;
        if (issue_c && (bus.id_br != BR_NONE)) state_nxt = BR_WAIT;
      end
      BR_WAIT: begin
        stall_c = 1'b1;
        if (bus.ex_br_valid) begin
          state_nxt = IDLE;
          flush_c   = bus.ex_br_taken;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky error for a branch resolution nobody was waiting for
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               br_err_q <= 1'b0;
    else if (state == IDLE && bus.ex_br_valid)  br_err_q <= 1'b1;
  end

  // Saturating count of cycles with fetch held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         stall_cnt_q <= '0;
    else if (stall_c && ~&stall_cnt_q)    stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign bus.stall_if   = stall_c;
  assign bus.issue      = issue_c;
  assign bus.bubble_ex  = ~issue_c;
  assign bus.flush_id   = flush_c;
  assign bus.br_pending = (state == BR_WAIT);
  assign bus.br_err     = br_err_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller between the instruction decoder (ID) and the EX/MEM/WB stages of the vector core.
- Tracks in-flight destination registers in a shadow scoreboard and stalls issue on RAW hazards.
- Holds fetch while a VBNZ/VBENZ branch resolves, and flushes ID on a taken branch.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_AW, 5, register address width.
- HAZ_DEPTH, 2, number of in-flight stages compared against ID sources (1..3; 1=EX, 2=EX+MEM, 3=EX+MEM+WB).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a decoded instruction.
- id_hdu_a  in  REG_AW  source A address from decoder.
- id_hdu_b  in  REG_AW  source B address from decoder.
- id_rd  in  REG_AW  destination address (arithmatic_RD).
- id_wr_en  in  1  instruction writes the register file.
- id_load  in  1  instruction is LD.
- id_br  in  2  branch type: 00 none, 10 VBNZ, 11 VBENZ.
- ex_br_valid  in  1  EX has resolved the branch this cycle.
- ex_br_taken  in  1  resolved branch is taken; qualified by ex_br_valid.
- stall_if  out  1  hold PC and the IF/ID register.
- bubble_ex  out  1  inject a NOP into ID/EX instead of the ID instruction.
- issue  out  1  ID instruction advances into EX this cycle.
- flush_id  out  1  one-cycle pulse; squash IF/ID contents.
- br_pending  out  1  FSM is in BR_WAIT.
- br_err  out  1  sticky flag: ex_br_valid seen while IDLE.
- stall_cnt  out  CNT_W  count of cycles with stall_if=1, saturating.

Behaviour:
- Reset (async, reset_n=0): all shadow entries invalid, FSM=IDLE, stall_cnt=0, br_err=0, flush_id=0. Combinational outputs then settle to stall_if=0, bubble_ex=!id_valid, issue=id_valid.
- Shadow pipe: three entries EX, MEM, WB, each {v, rd, load}. Every cycle: MEM<=EX, WB<=MEM. EX<={id_wr_en, id_rd, id_load} when issue=1, else invalid.
- Match on a source: entry v=1, entry rd == source, source != 0. Address 0 is never a hazard, since decoder uses 0 for unused fields.
- Only the first HAZ_DEPTH entries are compared.
- data_haz = id_valid and a match on id_hdu_a or id_hdu_b.
- FSM IDLE:
  - stall_if = data_haz.
  - issue = id_valid & !data_haz.
  - bubble_ex = !issue.
  - On issue with id_br != 00, go to BR_WAIT next cycle.
- FSM BR_WAIT:
  - stall_if=1, issue=0, bubble_ex=1.
  - On ex_br_valid: go to IDLE; flush_id = ex_br_taken in the same cycle (combinational, one cycle); stall_if stays 1 that cycle.
- ex_br_valid while IDLE: ignored for control; br_err set until reset.
- Reset asserted mid-BR_WAIT returns to IDLE with no flush.
- Data stall and branch issue together: the data stall wins; the branch issues once the hazard clears.
- stall_cnt increments on every cycle with stall_if=1 and holds at all-ones.
- Latency: hazard decision and outputs are combinational from ID inputs plus registered shadow state, with zero cycles of added delay.

Optional Feature:
- FORWARDING_EN defined: the EX/MEM bypass network exists.
  - A match stalls only if the matching entry is EX with load=1 (load-use).
  - A load-use hazard is exactly one stall cycle.
  - Non-load matches never stall.
- FORWARDING_EN undefined: any match within HAZ_DEPTH stalls, and the stall repeats until the producer leaves the compared window.

Decomposition:
- Shared package hazard_pkg:
  - BR_NONE=2'b00, BR_VBNZ=2'b10, BR_VBENZ=2'b11.
  - Shadow entry struct typedef {v, rd, load}.
  - FSM state enum {IDLE, BR_WAIT}.
- One sub-module, hazard_scoreboard: shadow shift register plus match logic, outputting data_haz.
- The top level holds the FSM and the counter.

Test Plan:
- R-type writing r5, then R-type reading r5 as src A, no FORWARDING_EN, HAZ_DEPTH=2 -> stall_if=1 for 2 cycles, then issue=1; stall_cnt=2.
- Same sequence with FORWARDING_EN -> no stall. LD r7 followed by a use of r7 -> exactly 1 stall cycle.
- Write r0, then read r0 -> stall_if never asserts.
- Issue VBNZ; ex_br_valid=1, ex_br_taken=1 after 3 cycles -> br_pending=1 for 3 cycles, flush_id pulses 1 cycle, FSM returns to IDLE. With taken=0 -> no flush.
- Pulse ex_br_valid while IDLE -> br_err=1 and held; deassert reset_n during BR_WAIT -> br_pending=0, stall_cnt=0, br_err=0, no flush_id.
- Force a 2^16+5 cycle stall -> stall_cnt saturates at 16'hFFFF.
